// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for pipe_hazard_ctrl: opcodes, FSM states, forward-select codes
// and the per-opcode source-register decode.
package pipe_hazard_ctrl_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_ADD     = 4'h1;
  localparam logic [3:0] OP_SUB     = 4'h2;
  localparam logic [3:0] OP_NAND    = 4'h3;
  localparam logic [3:0] OP_SHL     = 4'h4;
  localparam logic [3:0] OP_SHR     = 4'h5;
  localparam logic [3:0] OP_MOV     = 4'h6;
  localparam logic [3:0] OP_OUT     = 4'h7;
  localparam logic [3:0] OP_IN      = 4'h8;
  localparam logic [3:0] OP_BEQ     = 4'h9;
  localparam logic [3:0] OP_BNE     = 4'hA;
  localparam logic [3:0] OP_JMP     = 4'hB;
  localparam logic [3:0] OP_JAL     = 4'hC;
  localparam logic [3:0] OP_LOAD    = 4'hD;
  localparam logic [3:0] OP_STORE   = 4'hE;
  localparam logic [3:0] OP_LOADIMM = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_IO_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Slot A is the first operand read, slot B the second (STORE data lives in rd).
  typedef struct packed {
    logic       a_vld;
    logic [3:0] a;
    logic       b_vld;
    logic [3:0] b;
  } src_t;

  function automatic src_t src_regs(input logic [15:0] inst);
    src_t s;
    s = '0;
    case (inst[15:12])
      OP_ADD, OP_SUB, OP_NAND: begin
        s.a_vld = 1'b1; s.a = inst[7:4];
        s.b_vld = 1'b1; s.b = inst[3:0];
      end
      OP_SHL, OP_SHR, OP_MOV, OP_LOAD: begin
        s.a_vld = 1'b1; s.a = inst[7:4];
      end
      OP_OUT: begin
        s.a_vld = 1'b1; s.a = inst[11:8];
      end
      OP_STORE: begin
        s.a_vld = 1'b1; s.a = inst[7:4];
        s.b_vld = 1'b1; s.b = inst[11:8];
      end
      default: ;
    endcase
    return s;
  endfunction

  // The EX writer is the younger result, so it wins over MEM.
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex)
      return FWD_MEM;
    else if (hit_mem)
      return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_haz_src_match.sv
// haz_src_match: compares the source registers of the ID instruction against the
// EX and MEM writers. Bit 0 of each hit vector is source A, bit 1 is source B.
module haz_src_match
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [15:0] id_inst_i,
  input  logic        id_valid_i,
  input  logic [3:0]  ex_rd_i,
  input  logic        ex_reg_en_i,
  input  logic [3:0]  mem_rd_i,
  input  logic        mem_reg_en_i,
  output logic [1:0]  hit_ex_o,
  output logic [1:0]  hit_mem_o
);

  src_t       src;
  logic [1:0] src_vld;
  logic [3:0] src_reg [2];

  assign src        = src_regs(id_inst_i);
  assign src_vld    = {src.b_vld, src.a_vld} & {2{id_valid_i}};
  assign src_reg[0] = src.a;
  assign src_reg[1] = src.b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign hit_ex_o[gi]  = src_vld[gi] && ex_reg_en_i  && (src_reg[gi] == ex_rd_i);
    assign hit_mem_o[gi] = src_vld[gi] && mem_reg_en_i && (src_reg[gi] == mem_rd_i);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble/flush, operand-forward and OUT/IN handshake control.
// Define HAZ_FWD_EN to enable EX/MEM forwarding; otherwise any RAW on EX or MEM stalls.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC  = 2,
  parameter int IO_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] id_inst,
  input  logic        id_valid,
  input  logic [3:0]  ex_rd,
  input  logic [3:0]  mem_rd,
  input  logic        ex_reg_en,
  input  logic        mem_reg_en,
  input  logic        ex_is_load,
  input  logic        ex_br_taken,
  input  logic        io_ack,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        io_req,
  output logic        io_err
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);
  localparam logic [7:0] TO_LAST    = 8'(IO_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       io_err_q, io_err_d;
  logic [1:0] hit_ex, hit_mem;
  logic       data_haz, id_is_io;
  logic       stall, bubble, flush, req;

  haz_src_match u_src_match (
    .id_inst_i    (id_inst),
    .id_valid_i   (id_valid),
    .ex_rd_i      (ex_rd),
    .ex_reg_en_i  (ex_reg_en),
    .mem_rd_i     (mem_rd),
    .mem_reg_en_i (mem_reg_en),
    .hit_ex_o     (hit_ex),
    .hit_mem_o    (hit_mem)
  );

  assign id_is_io = id_valid && (id_inst[15:12] == OP_OUT || id_inst[15:12] == OP_IN);

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    tcnt_d   = tcnt_q;
    io_err_d = io_err_q;
    stall    = 1'b0;
    bubble   = 1'b0;
    flush    = 1'b0;
    req      = 1'b0;
    if (ex_br_taken) begin
      // A taken branch squashes wrong-path work from any state, including an I/O wait.
      flush   = 1'b1;
      bubble  = 1'b1;
      fcnt_d  = FLUSH_LOAD;
      state_d = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state_q)
        ST_IO_WAIT: begin
          req = 1'b1;
          if (io_ack) begin
            state_d = ST_RUN;
          end else if (tcnt_q == TO_LAST) begin
            io_err_d = 1'b1;
            state_d  = ST_RUN;
          end else begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          end
        end
        ST_FLUSH: begin
          flush  = 1'b1;
          bubble = 1'b1;
          if (fcnt_q <= 3'd1) begin
            fcnt_d  = 3'd0;
            state_d = ST_RUN;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
        default: begin
          if (id_is_io) begin
            req     = 1'b1;
            stall   = 1'b1;
            bubble  = 1'b1;
            tcnt_d  = 8'd0;
            state_d = ST_IO_WAIT;
          end else if (data_haz) begin
            stall  = 1'b1;
            bubble = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      fcnt_q   <= 3'd0;
      tcnt_q   <= 8'd0;
      io_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      tcnt_q   <= tcnt_d;
      io_err_q <= io_err_d;
    end
  end

`ifdef HAZ_FWD_EN
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  assign data_haz = ex_is_load & (|hit_ex);

  // Selects follow the instruction into EX: refreshed only when ID advances.
  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (bubble) begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end else if (!stall) begin
      fwd_a_d = fwd_sel(hit_ex[0], hit_mem[0]);
      fwd_b_d = fwd_sel(hit_ex[1], hit_mem[1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
`else
  logic unused_ex_is_load;

  assign unused_ex_is_load = ex_is_load;
  assign data_haz          = |{hit_ex, hit_mem};
  assign fwd_a_sel         = FWD_RF;
  assign fwd_b_sel         = FWD_RF;
`endif

  // Held low while reset is asserted so a mid-flush or mid-I/O reset silences everything.
  assign pc_stall     = rst_n & stall;
  assign if_id_stall  = rst_n & stall;
  assign id_ex_bubble = rst_n & bubble;
  assign if_id_flush  = rst_n & flush;
  assign io_req       = rst_n & req;
  assign io_err       = io_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model. Works with or without HAZ_FWD_EN.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int TB_FLUSH = 2;
  localparam int TB_TO    = 6;
  localparam logic [4:0] C_IDLE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11100;
  localparam logic [4:0] C_FLUSH = 5'b00110;
  localparam logic [4:0] C_IOST  = 5'b11101;
  localparam logic [4:0] C_IOREL = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] id_inst = '0;
  logic        id_valid = 1'b0;
  logic [3:0]  ex_rd = '0, mem_rd = '0;
  logic        ex_reg_en = 1'b0, mem_reg_en = 1'b0, ex_is_load = 1'b0;
  logic        ex_br_taken = 1'b0, io_ack = 1'b0;
  logic        pc_stall, if_id_stall, id_ex_bubble, if_id_flush, io_req, io_err;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [4:0]  ctl;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_ctrl #(.FLUSH_CYC(TB_FLUSH), .IO_TIMEOUT(TB_TO)) dut (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_reg_en(ex_reg_en), .mem_reg_en(mem_reg_en),
    .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken), .io_ack(io_ack),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .io_req(io_req), .io_err(io_err)
  );

  always #5 clk = ~clk;
  assign ctl = {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, io_req};

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] ra, input logic [3:0] rb);
    return {op, rd, ra, rb};
  endfunction

  task automatic set_in(input logic [15:0] inst, input logic vld, input logic [3:0] erd,
                        input logic een, input logic eld, input logic [3:0] mrd,
                        input logic men, input logic br, input logic ack);
    id_inst = inst; id_valid = vld; ex_rd = erd; ex_reg_en = een; ex_is_load = eld;
    mem_rd = mrd; mem_reg_en = men; ex_br_taken = br; io_ack = ack;
  endtask

  task automatic set_idle();
    set_in(16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(mk(OP_OUT, 4'd1, 4'd0, 4'd0), 1'b1, 4'd1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({ctl, fwd_a_sel, fwd_b_sel, io_err} !== 10'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b expected %b", {ctl, fwd_a_sel, fwd_b_sel, io_err}, 10'b0);
    end
    tick();
    rst_n = 1'b1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_errors++;
      $display("FAIL reset_run_idle: got %b expected %b", ctl, C_IDLE);
    end
    tick();
  endtask

  task automatic test_fwd_alu();
    logic [4:0] exp;
    set_in(mk(OP_SUB, 4'd5, 4'd1, 4'd2), 1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
`ifdef HAZ_FWD_EN
    exp = C_IDLE;
`else
    exp = C_STALL;
`endif
    n_checks++;
    if (ctl !== exp) begin
      n_errors++;
      $display("FAIL fwd_alu_ctl: got %b expected %b", ctl, exp);
    end
    tick();
    set_idle();
    @(negedge clk);
    n_checks++;
`ifdef HAZ_FWD_EN
    if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin
      n_errors++;
      $display("FAIL fwd_alu_sel: got a=%b b=%b expected a=01 b=00", fwd_a_sel, fwd_b_sel);
    end
`else
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      n_errors++;
      $display("FAIL fwd_alu_sel: got a=%b b=%b expected a=00 b=00", fwd_a_sel, fwd_b_sel);
    end
`endif
    tick();
  endtask

  task automatic test_load_use();
    logic [15:0] add_i;
    logic [4:0]  exp1;
    add_i = mk(OP_ADD, 4'd3, 4'd2, 4'd4);
    set_in(add_i, 1'b1, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (ctl !== C_STALL) begin
      n_errors++;
      $display("FAIL load_use_c0: got %b expected %b", ctl, C_STALL);
    end
    tick();
    set_in(add_i, 1'b1, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
`ifdef HAZ_FWD_EN
    exp1 = C_IDLE;
`else
    exp1 = C_STALL;
`endif
    n_checks++;
    if (ctl !== exp1 || fwd_a_sel !== 2'b00) begin
      n_errors++;
      $display("FAIL load_use_c1: got ctl=%b fa=%b expected ctl=%b fa=00", ctl, fwd_a_sel, exp1);
    end
    tick();
`ifdef HAZ_FWD_EN
    set_idle();
    @(negedge clk);
    n_checks++;
    if (ctl !== C_IDLE || fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
      n_errors++;
      $display("FAIL load_use_c2: got ctl=%b fa=%b fb=%b expected ctl=%b fa=10 fb=00",
               ctl, fwd_a_sel, fwd_b_sel, C_IDLE);
    end
`else
    set_in(add_i, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (ctl !== C_IDLE || fwd_a_sel !== 2'b00) begin
      n_errors++;
      $display("FAIL load_use_c2: got ctl=%b fa=%b expected ctl=%b fa=00", ctl, fwd_a_sel, C_IDLE);
    end
`endif
    tick();
  endtask

  task automatic test_branch_flush();
    logic [4:0] exp;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) set_in(mk(OP_ADD, 4'd1, 4'd2, 4'd3), 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      else        set_idle();
      @(negedge clk);
      exp = (k < TB_FLUSH) ? C_FLUSH : C_IDLE;
      n_checks++;
      if (ctl !== exp) begin
        n_errors++;
        $display("FAIL branch_flush c%0d: got %b expected %b", k, ctl, exp);
      end
      tick();
    end
  endtask

  task automatic test_io_ack();
    logic [4:0] exp;
    int req_cyc = 0, stall_cyc = 0;
    for (int k = 0; k < 7; k++) begin
      if (k < 6) set_in(mk(OP_OUT, 4'd7, 4'd0, 4'd0), 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, (k == 5));
      else       set_idle();
      @(negedge clk);
      exp = (k < 5) ? C_IOST : (k == 5) ? C_IOREL : C_IDLE;
      req_cyc += int'(io_req);
      stall_cyc += int'(pc_stall);
      n_checks++;
      if (ctl !== exp) begin
        n_errors++;
        $display("FAIL io_ack c%0d: got %b expected %b", k, ctl, exp);
      end
      tick();
    end
    n_checks++;
    if (req_cyc != 6 || stall_cyc != 5) begin
      n_errors++;
      $display("FAIL io_ack_len: got req=%0d stall=%0d expected req=6 stall=5", req_cyc, stall_cyc);
    end
  endtask

  task automatic test_io_timeout();
    logic [4:0] exp;
    for (int k = 0; k <= TB_TO + 1; k++) begin
      if (k <= TB_TO) set_in(mk(OP_IN, 4'd4, 4'd0, 4'd0), 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      else            set_idle();
      @(negedge clk);
      exp = (k < TB_TO) ? C_IOST : (k == TB_TO) ? C_IOREL : C_IDLE;
      n_checks++;
      if (ctl !== exp || io_err !== (k > TB_TO)) begin
        n_errors++;
        $display("FAIL io_timeout c%0d: got ctl=%b err=%b expected ctl=%b err=%b",
                 k, ctl, io_err, exp, (k > TB_TO));
      end
      tick();
    end
  endtask

  task automatic test_br_during_io();
    logic [4:0] exp;
    for (int k = 0; k < 4; k++) begin
      if (k < 2) set_in(mk(OP_OUT, 4'd7, 4'd0, 4'd0), 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, (k == 1), 1'b0);
      else       set_idle();
      @(negedge clk);
      exp = (k == 0) ? C_IOST : (k < 3) ? C_FLUSH : C_IDLE;
      n_checks++;
      if (ctl !== exp) begin
        n_errors++;
        $display("FAIL br_during_io c%0d: got %b expected %b", k, ctl, exp);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_flush();
    set_in(16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if (ctl !== C_FLUSH) begin
      n_errors++;
      $display("FAIL rst_flush_entry: got %b expected %b", ctl, C_FLUSH);
    end
    tick();
    rst_n = 1'b0;
    set_in(mk(OP_OUT, 4'd1, 4'd1, 4'd1), 1'b1, 4'd1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0);
    #2;
    n_checks++;
    if ({ctl, fwd_a_sel, fwd_b_sel, io_err} !== 10'b0) begin
      n_errors++;
      $display("FAIL rst_mid_flush: got %b expected %b", {ctl, fwd_a_sel, fwd_b_sel, io_err}, 10'b0);
    end
    tick();
    rst_n = 1'b1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (ctl !== C_IDLE || io_err !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_after: got ctl=%b err=%b expected ctl=%b err=0", ctl, io_err, C_IDLE);
    end
    tick();
  endtask

  // Operand reads per opcode, as listed in the instruction set description.
  function automatic void ref_srcs(input logic [15:0] i, output bit va, output logic [3:0] a,
                                   output bit vb, output logic [3:0] b);
    logic [3:0] op;
    op = i[15:12];
    va = op inside {OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR, OP_MOV, OP_LOAD, OP_OUT, OP_STORE};
    a  = (op == OP_OUT) ? i[11:8] : i[7:4];
    vb = op inside {OP_ADD, OP_SUB, OP_NAND, OP_STORE};
    b  = (op == OP_STORE) ? i[11:8] : i[3:0];
  endfunction

  task automatic test_random();
    int flush_left = 0, io_stalled = 0;
    bit err_m = 0;
    logic [1:0] fa_m = 2'b00, fb_m = 2'b00;
    logic [15:0] inst;
    logic vld, een, eld, men, br, ack, ha_e, hb_e, ha_m, hb_m, haz;
    logic [3:0] erd, mrd, a, b;
    bit va, vb;
    logic [4:0] exp;
    rst_n = 1'b0;
    set_idle();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      inst = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              4'($urandom_range(0, 3))};
      vld = ($urandom_range(0, 4) != 0);
      erd = 4'($urandom_range(0, 3)); een = 1'($urandom); eld = 1'($urandom);
      mrd = 4'($urandom_range(0, 3)); men = 1'($urandom);
      br  = ($urandom_range(0, 11) == 0);
      ack = ($urandom_range(0, 4) == 0);
      set_in(inst, vld, erd, een, eld, mrd, men, br, ack);
      ref_srcs(inst, va, a, vb, b);
      ha_e = vld && va && een && (a == erd);
      hb_e = vld && vb && een && (b == erd);
      ha_m = vld && va && men && (a == mrd);
      hb_m = vld && vb && men && (b == mrd);
`ifdef HAZ_FWD_EN
      haz = eld && (ha_e || hb_e);
`else
      haz = ha_e || hb_e || ha_m || hb_m;
`endif
      exp = C_IDLE;
      @(negedge clk);
      if (br) exp = C_FLUSH;
      else if (flush_left > 0) exp = C_FLUSH;
      else if (io_stalled > 0) exp = (ack || io_stalled == TB_TO) ? C_IOREL : C_IOST;
      else if (vld && (inst[15:12] == OP_OUT || inst[15:12] == OP_IN)) exp = C_IOST;
      else if (haz) exp = C_STALL;
      n_checks++;
      if ({ctl, fwd_a_sel, fwd_b_sel, io_err} !== {exp, fa_m, fb_m, err_m}) begin
        n_errors++;
        $display("FAIL random c%0d: got ctl=%b fa=%b fb=%b err=%b expected ctl=%b fa=%b fb=%b err=%b",
                 c, ctl, fwd_a_sel, fwd_b_sel, io_err, exp, fa_m, fb_m, err_m);
      end
      // advance the model to the next cycle
      if (br) begin
        flush_left = TB_FLUSH - 1; io_stalled = 0;
      end else if (flush_left > 0) begin
        flush_left--;
      end else if (io_stalled > 0) begin
        if (!ack && io_stalled == TB_TO) err_m = 1;
        io_stalled = (exp == C_IOST) ? io_stalled + 1 : 0;
      end else if (exp == C_IOST) begin
        io_stalled = 1;
      end
      if (exp[2]) begin
        fa_m = 2'b00; fb_m = 2'b00;
      end else if (!exp[4]) begin
`ifdef HAZ_FWD_EN
        fa_m = ha_e ? 2'b01 : ha_m ? 2'b10 : 2'b00;
        fb_m = hb_e ? 2'b01 : hb_m ? 2'b10 : 2'b00;
`else
        fa_m = 2'b00; fb_m = 2'b00;
`endif
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_branch_flush();
    test_io_ack();
    test_io_timeout();
    test_br_during_io();
    test_reset_mid_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing block for the 16-bit, 5-stage core (IF, ID, EX, MEM, WB). It sits beside the instruction decoder and watches the instruction in ID together with the write-back state of EX and MEM. From these it drives stall, bubble and flush controls, operand-forwarding selects, and the I/O handshake for OUT/IN. An internal FSM sequences branch flushes and I/O waits.

## Interface
- FLUSH_CYC, 2: wrong-path cycles squashed after a taken branch (1..7).
- IO_TIMEOUT, 255: maximum cycles to wait for io_ack (1..255).
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_inst  in  16  instruction in ID; opcode [15:12], rd [11:8], ra [7:4], rb [3:0].
- id_valid  in  1  id_inst is a real instruction.
- ex_rd, mem_rd  in  4  destination register of EX / MEM instruction.
- ex_reg_en, mem_reg_en  in  1  EX / MEM instruction writes rd.
- ex_is_load  in  1  EX instruction is LOAD (opcode 1101).
- ex_br_taken  in  1  branch in EX resolved taken this cycle.
- io_ack  in  1  I/O device completes transfer.
- pc_stall, if_id_stall  out  1  hold PC / IF-ID register.
- id_ex_bubble  out  1  load NOP controls into ID-EX.
- if_id_flush  out  1  clear IF-ID to NOP.
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 regfile, 01 MEM result, 10 WB result.
- io_req  out  1  I/O request for OUT/IN in ID.
- io_err  out  1  sticky; set on I/O timeout.

## Operation
- Source registers by opcode:
  - ADD/SUB/NAND: ra, rb.
  - SHL/SHR/MOV/LOAD: ra.
  - OUT: rd.
  - STORE: ra, rd.
  - All others: none.
- A source hits a stage when that stage's reg_en is 1 and its rd equals the source. The register file is write-through, so a WB-stage writer is never a hazard.
- FSM states:
  - RUN (reset state).
    - ex_br_taken: assert if_id_flush and id_ex_bubble, load the flush counter with FLUSH_CYC-1, go to FLUSH. If FLUSH_CYC=1, stay in RUN.
    - Else, valid OUT/IN in ID: assert io_req plus all three stall outputs, clear the timeout counter, go to IO_WAIT.
    - Else, a data hazard: assert pc_stall, if_id_stall and id_ex_bubble.
  - IO_WAIT.
    - io_req held high and stalls held.
    - io_ack: drop the stalls combinationally in that cycle, return to RUN.
    - Timeout counter reaches IO_TIMEOUT: set io_err, release the stalls, return to RUN.
    - ex_br_taken overrides both: drop io_req, flush as in RUN, go to FLUSH.
  - FLUSH.
    - if_id_flush and id_ex_bubble asserted each cycle; the counter decrements.
    - Counter reaching 0: return to RUN.
    - A new ex_br_taken reloads the counter.
- Priority: branch > I/O > data hazard.
- Forward selects are registered and updated only when ID advances into EX, i.e. when id_ex_bubble=0 and the stalls are low:
  - A source hitting EX selects 01.
  - Else a source hitting MEM selects 10.
  - Else 00.
  - They load 00 on a bubble.
- io_err clears only on reset.

## Timing
- Stall, bubble, flush and io_req are combinational from the current state and inputs, in the same cycle as detection.
- Forward selects take effect 1 cycle after capture, aligned with the instruction in EX.
- Load-use costs exactly 1 stall cycle, after which the load is in MEM.
- I/O costs a minimum of 1 cycle, when io_ack arrives in the entry cycle +1.
- Reset: state RUN; counters, fwd selects, io_req and io_err all 0; all stall/flush outputs 0.
- Reset asserted mid-FLUSH or mid-IO_WAIT aborts immediately.
- The counters saturate and never wrap.

## Configuration
- HAZ_FWD_EN defined:
  - Forwarding is active as above.
  - The only data hazard is a source hitting EX while ex_is_load=1.
- HAZ_FWD_EN undefined:
  - fwd_a_sel and fwd_b_sel are tied to 00.
  - A data hazard is any source hitting EX or MEM, which gives up to 2 stall cycles per dependency.

## Structure
- Shared package holds:
  - the opcode localparams (NOP..LOADIMM);
  - the FSM state enum;
  - the forward-select encodings;
  - the function returning the source-register set for an instruction.
- One sub-module, haz_src_match, compares the sources of id_inst against the EX and MEM writers. It outputs a hit vector per source and stage.

## Test plan
- ADD r1 in EX, then SUB reading r1 in ID (forwarding on) -> no stall; fwd_a_sel=01 the next cycle.
- LOAD r2 in EX, then ADD reading r2 in ID -> exactly 1 cycle of pc_stall/id_ex_bubble, then fwd_a_sel=10.
- HAZ_FWD_EN undefined, same LOAD/ADD pair -> 2 stall cycles; fwd selects stay 00.
- ex_br_taken with FLUSH_CYC=2 -> if_id_flush high for 2 cycles, then RUN.
- OUT in ID, io_ack after 5 cycles -> io_req high for 6 cycles, stalls drop in the ack cycle.
- IN in ID, no ack, IO_TIMEOUT=4 -> release after 4 cycles, io_err=1.
- ex_br_taken during IO_WAIT -> io_req drops the same cycle and state goes to FLUSH.
- Reset mid-FLUSH -> all outputs 0 while rst_n is low.
